freq_meas_ctrl: RTL and testbench

Sequencer for the frequency-measurement datapath. Generates a fixed gate window of GATE_CYCLES system clocks and counts rising edges of an asynchronous input over that window. It then latches the count as a frequency result and hands it to a consumer through a valid/ack handshake. Runs single-shot or continuously, and sits between the board input pin and the display/readout logic.

---
 rtl/freq_meas_pkg.sv | 15 +
 rtl/freq_meas_ctrl_if.sv | 27 ++
 rtl/freq_meas_ctrl_gate_timer.sv | 36 +++
 rtl/freq_meas_ctrl.sv | 134 +++++++++++++
 tb/tb_freq_meas_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-measurement sequencer: state encoding
// and default timing constants.
package freq_meas_pkg;

  localparam int unsigned DEF_CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_GATE_CYCLES = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Control and result handshake between the measurement sequencer (slave)
// and its requester/consumer (master).
interface freq_meas_ctrl_if #(
  parameter int unsigned CNT_W = 26
);

  logic             start;
  logic             continuous;
  logic             stop;
  logic             result_ack;
  logic [CNT_W-1:0] freq_count;
  logic             result_valid;
  logic             overflow;
  logic             overrun;
  logic             busy;

  modport master (
    output start, continuous, stop, result_ack,
    input  freq_count, result_valid, overflow, overrun, busy
  );

  modport slave (
    input  start, continuous, stop, result_ack,
    output freq_count, result_valid, overflow, overrun, busy
  );

endinterface

// File: rtl/freq_meas_ctrl_gate_timer.sv
// Gate window timer: counts run cycles from a clear and flags the final
// cycle of a GATE_CYCLES-long window with a registered last.
module gate_timer
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic last
);

  localparam int unsigned CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] PENULT = CW'(GATE_CYCLES - 2);

  logic [CW-1:0] cnt;

  // last is precomputed one cycle ahead so it equals (cnt == GATE_CYCLES-1)
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (run) begin
      if (last) begin
        cnt  <= '0;
        last <= 1'b0;
      end else begin
        cnt  <= cnt + CW'(1);
        last <= (cnt == PENULT);
      end
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Frequency-measurement sequencer: counts synchronized rising edges of sig_in
// over a fixed gate window and hands each result out on a valid/ack handshake.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig_in,
  freq_meas_ctrl_if.slave      bus
);

  localparam bit PARAMS_OK = (CLK_HZ > 0) && (GATE_CYCLES >= 2) && (SYNC_STAGES >= 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!PARAMS_OK) begin : g_param_check
    $error("freq_meas_ctrl: GATE_CYCLES and SYNC_STAGES must be >= 2, CLK_HZ > 0");
  end

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   edge_c;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   sat;
  logic                   gate_last;
  logic                   timer_clear_c;
  logic                   timer_run_c;

  // Input synchronizer and rising-edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c        = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign timer_clear_c = (state == ARM);
  assign timer_run_c   = (state == GATE);

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear_c),
    .run   (timer_run_c),
    .last  (gate_last)
  );

  // Sequencer, edge counter and result/handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      edge_cnt         <= '0;
      sat              <= 1'b0;
      bus.freq_count   <= '0;
      bus.result_valid <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      // An ack retires the result unless LATCH below publishes a new one
      if (bus.result_ack) begin
        bus.result_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state    <= ARM;
            bus.busy <= 1'b1;
          end
        end

        ARM: begin
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (bus.stop) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state <= GATE;
          end
        end

        GATE: begin
          if (edge_c) begin
            if (edge_cnt == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              edge_cnt <= edge_cnt + CNT_W'(1);
            end
          end
          if (bus.stop) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (gate_last) begin
            state <= LATCH;
          end
        end

        LATCH: begin
          bus.freq_count   <= edge_cnt;
          bus.overflow     <= sat;
          bus.result_valid <= 1'b1;
          if (bus.result_valid && !bus.result_ack) begin
            bus.overrun <= 1'b1;
          end
          if (bus.continuous && !bus.stop) begin
            state <= ARM;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: two instances (wide and 4-bit
// counter) share stimulus and are checked against a window-counting model.
module tb_freq_meas_ctrl;

  localparam int unsigned G    = 100;
  localparam int unsigned W_A  = 26;
  localparam int unsigned W_B  = 4;
  localparam int          HMAX = 16384;

  logic clk = 1'b0;
  logic reset;
  logic sig_in;

  freq_meas_ctrl_if #(.CNT_W(W_A)) if_a ();
  freq_meas_ctrl_if #(.CNT_W(W_B)) if_b ();

  freq_meas_ctrl #(
    .CLK_HZ(50_000_000), .GATE_CYCLES(G), .CNT_W(W_A), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(if_a)
  );

  freq_meas_ctrl #(
    .CLK_HZ(50_000_000), .GATE_CYCLES(G), .CNT_W(W_B), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(if_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit hist [HMAX];

  // sig_in generator: 0 = low, 1 = periodic, 2 = random bits, 3 = burst of gn pulses
  int gmode = 0, gper = 2, gphase = 0, gbase = 0, gn = 0;

  // Expected state of the last published result
  bit exp_valid = 1'b0;
  int exp_n     = 0;
  bit exp_ovr   = 1'b0;
  bit co        = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic bit gen_bit(input int c);
    int d;
    case (gmode)
      1:       return ((c + gphase) % gper) < (gper / 2);
      2:       return 1'($urandom % 2);
      3: begin
        d = c - gbase;
        return (d >= 0) && (d < 2 * gn) && (d % 2 == 1);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sig_in = gen_bit(cyc);
    if (cyc < HMAX) hist[cyc] = sig_in;
  endtask

  task automatic set_in(input bit st, input bit cont, input bit sp, input bit ak);
    if_a.start = st; if_a.continuous = cont; if_a.stop = sp; if_a.result_ack = ak;
    if_b.start = st; if_b.continuous = cont; if_b.stop = sp; if_b.result_ack = ak;
  endtask

  // Rising transitions of the driven input whose synchronized edge lands in the
  // gate of a window whose start request was driven in cycle s
  function automatic int rises(input int s);
    int n = 0;
    for (int k = s; k < s + int'(G); k++)
      if (hist[k] && !hist[k-1]) n++;
    return n;
  endfunction

  function automatic int sat_w(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic check_out(input string tag, input bit valid, input bit busy,
                           input int n, input bit ovr);
    check({tag, " a.valid"},    32'(if_a.result_valid), 32'(valid));
    check({tag, " a.busy"},     32'(if_a.busy),         32'(busy));
    check({tag, " a.count"},    32'(if_a.freq_count),   32'(sat_w(n, W_A)));
    check({tag, " a.overflow"}, 32'(if_a.overflow),     32'(n > sat_w(n, W_A)));
    check({tag, " a.overrun"},  32'(if_a.overrun),      32'(ovr));
    check({tag, " b.valid"},    32'(if_b.result_valid), 32'(valid));
    check({tag, " b.busy"},     32'(if_b.busy),         32'(busy));
    check({tag, " b.count"},    32'(if_b.freq_count),   32'(sat_w(n, W_B)));
    check({tag, " b.overflow"}, 32'(if_b.overflow),     32'(n > sat_w(n, W_B)));
    check({tag, " b.overrun"},  32'(if_b.overrun),      32'(ovr));
  endtask

  task automatic ack_result(input string tag);
    set_in(1'b0, co, 1'b0, 1'b1);
    tick();
    set_in(1'b0, co, 1'b0, 1'b0);
    exp_valid = 1'b0;
    check({tag, " ack a.valid"}, 32'(if_a.result_valid), 32'd0);
    check({tag, " ack b.valid"}, 32'(if_b.result_valid), 32'd0);
  endtask

  // Single-shot measurement with exact latency checks
  task automatic run_single(input string tag);
    int s;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    s = cyc;
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, " armed busy"}, 32'(if_a.busy), 32'd1);
    while (cyc < s + int'(G) + 2) tick();
    check({tag, " pre-latch valid"}, 32'(if_a.result_valid), 32'(exp_valid));
    tick();
    exp_n     = rises(s);
    exp_valid = 1'b1;
    check_out(tag, 1'b1, 1'b0, exp_n, exp_ovr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int s, sk, d;
    sig_in = 1'b0;
    reset  = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_out("reset", 1'b0, 1'b0, 0, 1'b0);
    reset = 1'b0;
    repeat (3) tick();

    // Period 10: 10 edges per gate
    gmode = 1; gper = 10; gphase = int'($urandom_range(0, 9));
    run_single("p10");
    check("p10 count const", 32'(if_a.freq_count), 32'd10);
    ack_result("p10");

    // Period 2 saturates the 4-bit counter, period 20 does not
    gper = 2; gphase = int'($urandom_range(0, 1));
    run_single("p2");
    ack_result("p2");
    gper = 20; gphase = int'($urandom_range(0, 19));
    run_single("p20");
    ack_result("p20");

    // Saturation boundary on the 4-bit counter: exactly 15 and 16 edges
    for (int i = 15; i <= 16; i++) begin
      gmode = 3; gn = i; gbase = cyc + 1;
      run_single($sformatf("burst%0d", i));
      ack_result($sformatf("burst%0d", i));
    end

    // Randomized periods and random bit streams
    for (int i = 0; i < 4; i++) begin
      gmode  = (i % 2 == 0) ? 1 : 2;
      gper   = int'($urandom_range(2, 30));
      gphase = int'($urandom_range(0, 29));
      run_single($sformatf("rnd%0d", i));
      ack_result($sformatf("rnd%0d", i));
    end

    // Continuous mode with timely acks, dropping continuous during the third window
    gmode = 1; gper = 4; gphase = int'($urandom_range(0, 3));
    co = 1'b1;
    set_in(1'b1, co, 1'b0, 1'b0);
    s = cyc;
    tick();
    set_in(1'b0, co, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sk = s + k * (int'(G) + 2);
      while (cyc < sk + int'(G) + 3) tick();
      exp_n = rises(sk);
      check_out($sformatf("cont%0d", k), 1'b1, (k < 2), exp_n, 1'b0);
      check($sformatf("cont%0d count25", k), 32'(if_a.freq_count), 32'd25);
      d = int'($urandom_range(1, 9));
      repeat (d - 1) tick();
      if (k == 1) co = 1'b0;
      ack_result($sformatf("cont%0d", k));
    end

    // Continuous with no acks: second LATCH overwrites an unacked result
    gmode = 2;
    co = 1'b1;
    set_in(1'b1, co, 1'b0, 1'b0);
    s = cyc;
    tick();
    set_in(1'b0, co, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      sk = s + k * (int'(G) + 2);
      while (cyc < sk + int'(G) + 3) tick();
      exp_n = rises(sk);
      exp_ovr = (k == 1);
      check_out($sformatf("ovr%0d", k), 1'b1, 1'b1, exp_n, exp_ovr);
    end
    co = 1'b0;
    set_in(1'b0, co, 1'b1, 1'b0);
    tick();
    set_in(1'b0, co, 1'b0, 1'b0);
    exp_valid = 1'b1;
    check_out("ovr stop", 1'b1, 1'b0, exp_n, 1'b1);
    ack_result("ovr");

    // Stop in the middle of the gate leaves the previous result untouched
    gmode = 1; gper = 10; gphase = 0;
    run_single("pre-stop");
    gper = 3;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    s = cyc;
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    while (cyc < s + 52) tick();
    check("stop gate busy", 32'(if_a.busy), 32'd1);
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_out("stop", 1'b1, 1'b0, exp_n, 1'b1);
    repeat (G + 5) tick();
    check_out("stop idle", 1'b1, 1'b0, exp_n, 1'b1);
    ack_result("stop");

    // start and stop together in IDLE: no measurement
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check("start+stop busy", 32'(if_a.busy), 32'd0);
    repeat (G + 5) tick();
    check_out("start+stop", 1'b0, 1'b0, exp_n, 1'b1);

    // Reset during GATE with a valid result pending
    gper = 7; gphase = int'($urandom_range(0, 6));
    run_single("pre-reset");
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    s = cyc;
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    while (cyc < s + 30) tick();
    reset = 1'b1;
    tick();
    check_out("mid reset", 1'b0, 1'b0, 0, 1'b0);
    reset = 1'b0;
    exp_valid = 1'b0; exp_n = 0; exp_ovr = 1'b0;
    repeat (4) tick();
    check_out("post reset", 1'b0, 1'b0, 0, 1'b0);
    gmode = 2;
    run_single("fresh");
    ack_result("fresh");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
